fsm_16bit: RTL and testbench
============================

Name: fsm_16bit

Overview:
- Small 16-bit controlled-register state machine. Idles at zero, loads a fixed seed value when enabled, then on each "check" cycle modifies the register arithmetically or by rotation.
- Used as a self-contained datapath/controller exercise block. The register value is the only output.

Parameters:
- SEED, 16'h6453, value loaded on leaving IDLE.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and outputValue = 0.
- enable  input  1  starts the machine from IDLE; qualifies all updates in ACTIVE.
- check  input  1  when high in ACTIVE with enable, performs one operation per cycle.
- mode  input  1  0 = arithmetic (add/subtract value), 1 = rotate by one bit.
- direction  input  1  mode 0: 1 = add, 0 = subtract. Mode 1: 1 = rotate left, 0 = rotate right.
- value  input  4  unsigned step for arithmetic mode, zero-extended to 16 bits. Ignored in rotate mode.
- outputValue  output  16  registered state value.

Behaviour:
- Reset:
  - reset high, asynchronously and at any time (including mid-operation): state = IDLE, outputValue = 16'h0000.
  - Held while reset is high.
  - On deassertion, the first possible action is at the next rising edge.
- States:
  - IDLE and ACTIVE. Encoded in a registered state variable.
  - outputValue is a register, not a combinational function of the inputs.
- IDLE:
  - enable = 0: stay IDLE, outputValue holds 0.
  - enable = 1 at a rising edge: go to ACTIVE and load outputValue = SEED.
  - check, mode, direction and value are ignored on this edge. Seed load always wins.
- ACTIVE, per rising edge:
  - enable = 0: hold outputValue, stay ACTIVE.
  - enable = 1, check = 0: hold outputValue.
  - enable = 1, check = 1, mode = 0, direction = 1: outputValue <= outputValue + {12'b0, value}, modulo 2^16 (FFFF + 1 wraps to 0000).
  - enable = 1, check = 1, mode = 0, direction = 0: outputValue <= outputValue - {12'b0, value}, modulo 2^16 (0000 - 1 wraps to FFFF).
  - enable = 1, check = 1, mode = 1, direction = 1: rotate left by 1, {out[14:0], out[15]}.
  - enable = 1, check = 1, mode = 1, direction = 0: rotate right by 1, {out[0], out[15:1]}.
- Operation rules:
  - Exactly one operation per rising edge while check stays high. Operations repeat every cycle; check is level-sensitive, not edge-detected.
  - Latency: an input change that is set up before a rising edge is reflected in outputValue immediately after that edge (one-cycle registered latency).
  - value = 0 in arithmetic mode leaves outputValue unchanged.
  - No return from ACTIVE to IDLE except through reset.
  - No overflow or carry flags; wrap is silent.

Test Plan:
- Reset/idle: assert reset, then release with enable = 0 for 2 cycles -> outputValue = 0000 throughout. Assert reset mid-run in ACTIVE -> outputValue = 0000 immediately, without waiting for a clock edge.
- Seed load: enable = 1, check = 0, value = 3 -> 6453 after the first edge; holds 6453 on the following edge.
- Arithmetic: from 6453, check = 1, mode = 0:
  - direction = 0, value = 3 -> 6450.
  - direction = 1 -> 6453.
  - value = 5 -> 6458.
  - direction = 0 -> 6453.
- Rotate: from 6453, mode = 1:
  - direction = 0 -> B229.
  - direction = 1 -> 6453.
  - Confirm value = 5 has no effect in this mode.
- Wrap-around: drive the register to 0002 via subtracts, then subtract value 5 -> FFFD. Add 5 -> 0002.
- Hold conditions: in ACTIVE, set enable = 0 with check = 1 for 3 cycles -> value unchanged. Set enable = 1, check = 0 -> value unchanged.

Source files
------------

// File: rtl/fsm_16bit.sv
// Two-state controlled 16-bit register: IDLE holds zero, enabling loads SEED,
// then each enabled "check" cycle adds, subtracts or rotates the register.
module fsm_16bit #(
    parameter logic [15:0] SEED = 16'h6453
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        check,
    input  logic        mode,
    input  logic        direction,
    input  logic [3:0]  value,
    output logic [15:0] outputValue
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] next_value;
    logic [15:0] step;

    assign step = {12'b0, value};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            outputValue <= 16'h0000;
        end else begin
            state       <= next_state;
            outputValue <= next_value;
        end
    end

    // NOTE: defaults come first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        next_value = outputValue;
        case (state)
            IDLE: begin
                // Seed load wins over whatever operation is requested.
                if (enable) begin
                    next_state = ACTIVE;
                    next_value = SEED;
                end
            end
            ACTIVE: begin
                if (enable && check) begin
                    if (!mode) begin
                        next_value = direction ? (outputValue + step)
                                               : (outputValue - step);
                    end else begin
                        next_value = direction ? {outputValue[14:0], outputValue[15]}
                                               : {outputValue[0], outputValue[15:1]};
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_value = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_16bit.sv
// Directed bench for fsm_16bit: an integer-arithmetic model is compared on
// every falling edge, and literal expectations pin the model at key points.
module tb_fsm_16bit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        check = 1'b0;
    logic        mode = 1'b0;
    logic        direction = 1'b0;
    logic [3:0]  value = 4'd0;
    logic [15:0] outputValue;

    int tests_run = 0;
    int tests_failed = 0;

    bit m_active = 1'b0;
    int m_val = 0;
    bit cmp_en = 1'b0;

    fsm_16bit dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .check       (check),
        .mode        (mode),
        .direction   (direction),
        .value       (value),
        .outputValue (outputValue)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register value as a plain integer in 0..65535.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_val    <= 0;
        end else if (!m_active) begin
            if (enable) begin
                m_active <= 1'b1;
                m_val    <= 25683;
            end
        end else if (enable && check) begin
            if (!mode && direction)
                m_val <= (m_val + int'(value)) % 65536;
            else if (!mode)
                m_val <= (m_val - int'(value) + 65536) % 65536;
            else if (direction)
                m_val <= (m_val * 2) % 65536 + m_val / 32768;
            else
                m_val <= m_val / 2 + (m_val % 2) * 32768;
        end
    end

    always @(negedge clock) begin
        if (cmp_en)
            check_val("model", outputValue, 16'(m_val));
    end

    task automatic step(input logic en, input logic chk, input logic md,
                        input logic dir, input logic [3:0] val);
        enable    = en;
        check     = chk;
        mode      = md;
        direction = dir;
        value     = val;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        cmp_en = 1'b1;
        check_val("reset_hold", outputValue, 16'h0000);
        reset = 1'b0;

        step(0, 0, 0, 0, 4'd0);
        check_val("idle_1", outputValue, 16'h0000);
        step(0, 1, 0, 1, 4'd7);
        check_val("idle_2", outputValue, 16'h0000);

        step(1, 0, 0, 0, 4'd3);
        check_val("seed_load", outputValue, 16'h6453);
        step(1, 0, 0, 0, 4'd3);
        check_val("seed_hold", outputValue, 16'h6453);

        step(1, 1, 0, 0, 4'd3);
        check_val("sub_3", outputValue, 16'h6450);
        step(1, 1, 0, 1, 4'd3);
        check_val("add_3", outputValue, 16'h6453);
        step(1, 1, 0, 1, 4'd5);
        check_val("add_5", outputValue, 16'h6458);
        step(1, 1, 0, 0, 4'd5);
        check_val("sub_5", outputValue, 16'h6453);

        step(1, 1, 1, 0, 4'd5);
        check_val("rot_right", outputValue, 16'hB229);
        step(1, 1, 1, 1, 4'd5);
        check_val("rot_left", outputValue, 16'h6453);
        step(1, 1, 1, 1, 4'd0);
        check_val("rot_left_val0", outputValue, 16'hC8A6);
        step(1, 1, 1, 0, 4'd9);
        check_val("rot_right_val9", outputValue, 16'h6453);

        step(1, 1, 0, 1, 4'd0);
        check_val("add_zero", outputValue, 16'h6453);

        for (int i = 0; i < 1712; i++)
            step(1, 1, 0, 0, 4'd15);
        step(1, 1, 0, 0, 4'd1);
        check_val("down_to_2", outputValue, 16'h0002);
        step(1, 1, 0, 0, 4'd5);
        check_val("wrap_sub", outputValue, 16'hFFFD);
        step(1, 1, 0, 1, 4'd5);
        check_val("wrap_add", outputValue, 16'h0002);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 4'd5);
            check_val("hold_en0", outputValue, 16'h0002);
        end
        step(1, 0, 0, 1, 4'd5);
        check_val("hold_chk0", outputValue, 16'h0002);

        enable = 1'b1;
        check  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_reset", outputValue, 16'h0000);
        @(posedge clock);
        #1;
        check_val("reset_held", outputValue, 16'h0000);
        reset = 1'b0;

        step(0, 1, 0, 1, 4'd5);
        check_val("idle_after_reset", outputValue, 16'h0000);
        step(1, 1, 0, 1, 4'd5);
        check_val("reseed", outputValue, 16'h6453);
        step(1, 1, 0, 1, 4'd5);
        check_val("add_after_reseed", outputValue, 16'h6458);

        @(negedge clock);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
